solver_job_scheduler: RTL

Sequencing controller for one `block_solver` core. It accepts mining jobs (midstate, header leftovers, target) over a valid/ready interface and buffers up to two of them. For each job it runs the solver through a reset/run/report cycle and returns the outcome (found nonce or exhausted) over a second valid/ready interface. A flush input lets a new job abort in-flight work, so the block sits between the host job interface and the solver core.

---
 rtl/solver_job_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/solver_job_scheduler.sv
// Job sequencer for one block_solver core: two-deep job queue, a
// load/run/report cycle per job, and flush-driven abort of in-flight work.
module solver_job_scheduler #(
    parameter int unsigned ID_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic            job_flush,
    input  logic [255:0]    job_midstate,
    input  logic [95:0]     job_leftovers,
    input  logic [255:0]    job_target,
    output logic            solver_rst_n,
    output logic [255:0]    solver_midstate,
    output logic [95:0]     solver_leftovers,
    output logic [255:0]    solver_target,
    input  logic [2:0]      solver_state,
    input  logic [31:0]     solver_nonce,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_found,
    output logic [31:0]     res_nonce,
    output logic [ID_W-1:0] res_job_id,
    output logic [31:0]     res_cycles,
    output logic            busy
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT
    } state_t;

    typedef struct packed {
        logic [255:0]    midstate;
        logic [95:0]     leftovers;
        logic [255:0]    target;
        logic [ID_W-1:0] id;
    } job_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    job_t             q0, q1, q0_n, q1_n;
    job_t             new_job, pop_job;
    logic [ID_W-1:0]  next_id;
    logic [ID_W-1:0]  active_id;
    logic [31:0]      cyc;
    logic             accept, flush_acc, handshake, pop, done;

    // Ready depends only on queue occupancy; a flush always makes room.
    always_comb begin
        job_ready = (count != CNT_W'(2)) | job_flush;
        accept    = job_valid & job_ready;
        flush_acc = accept & job_flush;
        handshake = res_valid & res_ready;
        done      = (solver_state == 3'd4) | (solver_state == 3'd5);
        new_job   = '{midstate: job_midstate, leftovers: job_leftovers,
                      target: job_target, id: next_id};
    end

    // Next-state logic; pop marks a head dequeue into the solver registers.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!flush_acc && count != '0) begin
                    pop     = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                state_n = flush_acc ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (flush_acc)
                    state_n = S_IDLE;
                else if (done)
                    state_n = S_REPORT;
            end
            S_REPORT: begin
                if (handshake) begin
                    if (flush_acc || count != '0) begin
                        pop     = 1'b1;
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Queue update; a flush collapses the queue to the new job (or hands it straight to the solver).
    always_comb begin
        q0_n    = q0;
        q1_n    = q1;
        count_n = count;
        pop_job = flush_acc ? new_job : q0;
        if (flush_acc) begin
            if (pop) begin
                count_n = '0;
            end else begin
                q0_n    = new_job;
                count_n = CNT_W'(1);
            end
        end else begin
            unique case ({accept, pop})
                2'b11: begin
                    if (count == CNT_W'(1)) begin
                        q0_n = new_job;
                    end else begin
                        q0_n = q1;
                        q1_n = new_job;
                    end
                end
                2'b10: begin
                    if (count == '0)
                        q0_n = new_job;
                    else
                        q1_n = new_job;
                    count_n = count + CNT_W'(1);
                end
                2'b01: begin
                    q0_n    = q1;
                    count_n = count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // FSM, queue and ID counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= '0;
            q0      <= '0;
            q1      <= '0;
            next_id <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            q0    <= q0_n;
            q1    <= q1_n;
            if (accept)
                next_id <= next_id + ID_W'(1);
        end
    end

    // Solver-facing registers and the saturating RUN cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            solver_midstate  <= '0;
            solver_leftovers <= '0;
            solver_target    <= '0;
            active_id        <= '0;
            cyc              <= '0;
            solver_rst_n     <= 1'b0;
        end else begin
            solver_rst_n <= (state_n == S_RUN);
            if (pop) begin
                solver_midstate  <= pop_job.midstate;
                solver_leftovers <= pop_job.leftovers;
                solver_target    <= pop_job.target;
                active_id        <= pop_job.id;
                cyc              <= '0;
            end else if (state == S_RUN && cyc != '1) begin
                cyc <= cyc + 32'd1;
            end
        end
    end

    // Result capture on completion; held stable through REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_job_id <= '0;
            res_cycles <= '0;
            busy       <= 1'b0;
        end else begin
            res_valid <= (state_n == S_REPORT);
            busy      <= (state_n != S_IDLE) || (count_n != '0);
            if (state == S_RUN && !flush_acc && done) begin
                res_found  <= (solver_state == 3'd4);
                res_nonce  <= (solver_state == 3'd4) ? solver_nonce : 32'hFFFF_FFFF;
                res_job_id <= active_id;
                res_cycles <= (cyc == '1) ? cyc : cyc + 32'd1;
            end
        end
    end

endmodule
